// File: rtl/ldd_toggle_monitor.sv
// Switching-activity monitor for the ldd decoder output: sums per-sample toggle counts over a window
// and hands each window total downstream. Optional peak tracking is built when LDD_TOGGLE_PEAK_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first sample, which only primes prev
// RUN   | scoring accepted samples into the window accumulator
// HOLD  | window result presented on win_*, waiting for win_ready
module ldd_toggle_monitor #(
  parameter int WIDTH  = 19,
  parameter int WINDOW = 256,
  parameter int ACC_W  = 16,
  localparam int PK_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ACC_W-1:0] win_toggles,
  output logic [PK_W-1:0]  win_peak,
  output logic             win_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W-1:0] win_toggles_r;
  logic             win_ovf_r;

  logic [WIDTH-1:0] diff;
  logic [PK_W-1:0]  toggles;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             accept;
  logic             score;
  logic             last;
  logic             handshake;

  assign accept    = in_valid && in_ready;
  assign score     = accept && (state == RUN);
  assign last      = (cnt == CNT_W'(WINDOW - 1));
  assign handshake = win_valid && win_ready;

  always_comb begin
    diff    = in_vec ^ prev;
    toggles = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggles = toggles + PK_W'(diff[i]);
    end
  end

  // One extra bit catches the carry so the accumulator can clip instead of wrapping.
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(toggles);
  assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign ovf_nxt = ovf | sum[ACC_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = HOLD;
      HOLD:    if (win_ready) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (state != HOLD);
    win_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      prev          <= '0;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      win_toggles_r <= '0;
      win_ovf_r     <= 1'b0;
    end else begin
      if (accept) prev <= in_vec;
      if (score) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          win_toggles_r <= acc_nxt;
          win_ovf_r     <= ovf_nxt;
        end
      end else if (handshake) begin
        // prev is kept so the next window scores continuity against the last sample
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end
    end
  end

  assign win_toggles = win_toggles_r;
  assign win_ovf     = win_ovf_r;

`ifdef LDD_TOGGLE_PEAK_EN
  logic [PK_W-1:0] peak;
  logic [PK_W-1:0] peak_nxt;
  logic [PK_W-1:0] win_peak_r;

  assign peak_nxt = (toggles > peak) ? toggles : peak;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      peak       <= '0;
      win_peak_r <= '0;
    end else if (score) begin
      peak <= peak_nxt;
      if (last) win_peak_r <= peak_nxt;
    end else if (handshake) begin
      peak <= '0;
    end
  end

  assign win_peak = win_peak_r;
`else
  assign win_peak = '0;
`endif

endmodule

// File: tb/tb_ldd_toggle_monitor.sv
// Directed bench for ldd_toggle_monitor: WINDOW=4, a 16-bit and a 6-bit accumulator instance in lockstep.
// Expected peak depends on whether LDD_TOGGLE_PEAK_EN is defined for the build.
module tb_ldd_toggle_monitor;

`ifdef LDD_TOGGLE_PEAK_EN
  localparam int PEAK_ON = 1;
`else
  localparam int PEAK_ON = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [18:0] in_vec;
  logic        win_ready;
  logic        win_valid, win_valid_s;
  logic [15:0] win_toggles;
  logic [5:0]  win_toggles_s;
  logic [4:0]  win_peak, win_peak_s;
  logic        win_ovf, win_ovf_s;
  logic        busy, busy_s;

  int n_checks = 0;
  int n_fail   = 0;

  ldd_toggle_monitor #(.WIDTH(19), .WINDOW(4), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_toggles(win_toggles), .win_peak(win_peak), .win_ovf(win_ovf),
    .busy(busy)
  );

  ldd_toggle_monitor #(.WIDTH(19), .WINDOW(4), .ACC_W(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_vec(in_vec),
    .win_valid(win_valid_s), .win_ready(win_ready),
    .win_toggles(win_toggles_s), .win_peak(win_peak_s), .win_ovf(win_ovf_s),
    .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [18:0] v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    win_ready = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_valid", 32'(win_valid), 0);
    check("rst_win_toggles", 32'(win_toggles), 0);
    check("rst_win_peak", 32'(win_peak), 0);
    check("rst_win_ovf", 32'(win_ovf), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // full-swing window, consumer always ready
    send(19'h00000); send(19'h7FFFF); send(19'h00000); send(19'h7FFFF); send(19'h00000);
    check("t2_win_valid", 32'(win_valid), 1);
    check("t2_win_toggles", 32'(win_toggles), 76);
    check("t2_win_peak", 32'(win_peak), PEAK_ON ? 19 : 0);
    check("t2_win_ovf", 32'(win_ovf), 0);
    check("t2_busy", 32'(busy), 1);
    check("t2_in_ready", 32'(in_ready), 0);
    check("t4_sat_toggles", 32'(win_toggles_s), 63);
    check("t4_sat_ovf", 32'(win_ovf_s), 1);
    @(posedge clk); #1;
    check("t2_valid_drop", 32'(win_valid), 0);
    check("t2_toggles_hold", 32'(win_toggles), 76);

    // backpressure: result held for 10 cycles
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    win_ready = 1'b0;
    send(19'h00000); send(19'h7FFFF); send(19'h00000); send(19'h7FFFF); send(19'h00000);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("t3_hold_in_ready", 32'(in_ready), 0);
      check("t3_hold_valid", 32'(win_valid), 1);
      check("t3_hold_toggles", 32'(win_toggles), 76);
    end
    win_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_hs_valid", 32'(win_valid), 0);
    check("t3_hs_toggles", 32'(win_toggles), 76);
    check("t3_hs_busy", 32'(busy), 1);
    send(19'h00001); send(19'h00001); send(19'h00001); send(19'h00001);
    check("t3_w2_valid", 32'(win_valid), 1);
    check("t3_w2_toggles", 32'(win_toggles), 1);
    check("t3_w2_peak", 32'(win_peak), PEAK_ON ? 1 : 0);
    check("t3_w2_ovf", 32'(win_ovf), 0);
    check("t3_w2_sat_toggles", 32'(win_toggles_s), 1);
    check("t3_w2_sat_ovf", 32'(win_ovf_s), 0);
    @(posedge clk); #1;

    // clear mid-window, with a sample offered on the clear cycle
    send(19'h00003); send(19'h00000);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 19'h7FFFF;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_win_valid", 32'(win_valid), 0);
    check("t5_win_toggles", 32'(win_toggles), 0);
    check("t5_win_peak", 32'(win_peak), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    send(19'h00000);
    check("t5_prime_busy", 32'(busy), 1);
    send(19'h7FFFF); send(19'h00000); send(19'h7FFFF);
    check("t5_not_done", 32'(win_valid), 0);
    send(19'h00000);
    check("t5_win_valid", 32'(win_valid), 1);
    check("t5_win_toggles_end", 32'(win_toggles), 76);
    check("t5_win_peak_end", 32'(win_peak), PEAK_ON ? 19 : 0);
    check("t5_sat_toggles", 32'(win_toggles_s), 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
